forget_sig_interp: RTL and testbench
====================================

// Module: forget_sig_interp
// PURPOSE
// - Downstream consumer of the forget-gate sigmoid LUT: turns a signed Q3.4 pre-activation into the sigmoid output by piecewise-linear interpolation.
// - Splits the input into a LUT address and a fraction, and drives the LUT address combinationally from a pipeline register.
// - Captures the LUT's base and next_data values, then computes base + ((next - base) * frac) >>> FRAC_W.
// - Sits between the layer0 accumulator and the forget-gate multiplier, with valid/ready on both sides.
// PARAMETERS
// - DATA_W  8  width of input pre-activation, LUT entries and output (signed)
// - ADDR_W  4  LUT address width; address = in_data[DATA_W-1 -: ADDR_W], signed two's-complement segment index
// - FRAC_W  4  fraction width; frac = in_data[FRAC_W-1:0], unsigned; DATA_W == ADDR_W + FRAC_W
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       synchronous reset, active-high
// - in_valid     in   1       in_data valid
// - in_ready     out  1       block accepts in_data this cycle
// - in_data      in   DATA_W  signed pre-activation, Q3.4
// - lut_address  out  ADDR_W  to LUT address
// - lut_base     in   DATA_W  LUT base (lut[address]), combinational response
// - lut_next     in   DATA_W  LUT next__data (wrap and clamp handled inside the LUT)
// - out_valid    out  1       out_data valid
// - out_ready    in   1       downstream accepts out_data
// - out_data     out  DATA_W  signed interpolated sigmoid
// BEHAVIOUR
// - Pipeline and latency
//   - 3-stage pipeline.
//   - S0 registers in_data and its valid.
//   - S1 drives lut_address from the S0 register, then registers base, next and frac.
//   - S2 registers prod = (next - base) * frac.
//   - S3 registers out_data = sat(base + (prod >>> FRAC_W)).
//   - Accept at cycle t gives out_valid at t+3 when there is no stall.
// - Stall rule
//   - Global enable en = !out_valid | out_ready; in_ready = en.
//   - When en=0, all stage registers, valids and lut_address hold.
//   - The LUT is combinational, so a held address re-reads the same data.
// - Handshake
//   - Transfer on in_valid & in_ready. Output is consumed on out_valid & out_ready.
//   - out_data is stable while out_valid & !out_ready.
//   - Bubbles propagate as valid=0 stages; data registers of invalid stages are don't-care but must be held.
// - Arithmetic
//   - diff = next - base, DATA_W+1 bits signed.
//   - prod = diff * frac (frac zero-extended), DATA_W+FRAC_W+1 bits signed.
//   - Shift is arithmetic, truncating toward -inf.
//   - The sum is DATA_W+2 bits, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
// - Reset
//   - All valids and out_valid = 0; in_ready = 1 the cycle after reset deasserts.
//   - out_data = 0; lut_address = 0.
//   - Reset mid-operation flushes all in-flight data; nothing partial is emitted.
// - Boundaries
//   - Address 2^(ADDR_W-1)-1 (top segment): the LUT returns next = base, so the output is flat.
//   - Address 2^ADDR_W-1 (-1): next is lut[0], so interpolation crosses zero seamlessly.
//   - frac = 0 returns base exactly.
//   - Simultaneous out-consume and in-accept in one cycle sustains 1 result per cycle.
// STRUCTURE
// - Shared package lstm_fix_pkg:
//   - DATA_W, ADDR_W, FRAC_W constants
//   - typedef fix8_t (signed DATA_W)
//   - function sat_fix(), reused by the other gate interpolators
// - One sub-module: forget_sig_interp_mac, the combinational diff*frac and add-saturate datapath, instantiated between S1/S2/S3.
// - The LUT stays external (shared per gate), connected via lut_address/lut_base/lut_next.
// TESTING (LUT = forget sigmoid table: 8,11,14,15,15,15,15,15,0,0,0,0,0,0,1,4)
// - in_data=0x00, out_ready=1 -> lut_address=0, out_data=8 exactly 3 cycles after accept.
// - in_data=0x08 -> out_data=9; in_data=0xE8 -> out_data=2 (segment 14, base 1, next 4, frac 8).
// - in_data=0x78 -> out_data=15 (top-segment clamp); in_data=0x80 -> out_data=0.
// - in_data=0xF8 -> out_data=6 (address 15 wraps next to lut[0]=8).
// - Back-to-back stream 0x00,0x08,0x78,0xF8 with out_ready low for 4 cycles mid-stream:
//   - in_ready=0 while stalled.
//   - out_data stable while stalled.
//   - Results 8,9,15,6 in order, none lost or duplicated.
// - rst asserted for 1 cycle with 2 items in flight:
//   - out_valid=0 next cycle; no stale outputs after release.
//   - Next input 0x00 -> 8 after 3 cycles.

Source files
------------

// File: rtl/lstm_fix_pkg.sv
// Fixed-point types and helpers shared by the LSTM gate interpolators.
package lstm_fix_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int FRAC_W = 4;

    typedef logic signed [DATA_W-1:0]        fix8_t;
    typedef logic signed [DATA_W:0]          diff_t;
    typedef logic signed [DATA_W+FRAC_W:0]   prod_t;
    typedef logic signed [DATA_W+1:0]        sum_t;

    localparam fix8_t FIX_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam fix8_t FIX_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Clamp a widened sum back into the signed DATA_W range.
    function automatic fix8_t sat_fix(input sum_t x);
        if (x > sum_t'(FIX_MAX)) begin
            return FIX_MAX;
        end else if (x < sum_t'(FIX_MIN)) begin
            return FIX_MIN;
        end else begin
            return x[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/forget_sig_interp_mac.sv
// Combinational interpolation datapath: (next - base) * frac, then base + (prod >>> FRAC_W) saturated.
module forget_sig_interp_mac
    import lstm_fix_pkg::*;
(
    input  fix8_t              base_i,
    input  fix8_t              next_i,
    input  logic [FRAC_W-1:0]  frac_i,
    output prod_t              prod_o,
    input  fix8_t              acc_base_i,
    input  prod_t              acc_prod_i,
    output fix8_t              sum_o
);

    diff_t diff;
    prod_t frac_ext;
    prod_t shifted;
    sum_t  sum;

    always_comb begin
        diff     = diff_t'(next_i) - diff_t'(base_i);
        frac_ext = prod_t'($signed({1'b0, frac_i}));
        prod_o   = prod_t'(diff) * frac_ext;
    end

    // Shifted product fits well inside sum_t, so the narrowing cast loses nothing.
    always_comb begin
        shifted = acc_prod_i >>> FRAC_W;
        sum     = sum_t'(acc_base_i) + sum_t'(shifted);
        sum_o   = sat_fix(sum);
    end

endmodule

// File: rtl/forget_sig_interp.sv
// Forget-gate sigmoid: 3-stage piecewise-linear interpolation over an external LUT.
module forget_sig_interp
    import lstm_fix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] lut_address,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              en;

    logic [DATA_W-1:0] s0_data_q;
    logic              s0_valid_q;

    fix8_t             s1_base_q;
    fix8_t             s1_next_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic              s1_valid_q;

    fix8_t             s2_base_q;
    prod_t             s2_prod_q;
    logic              s2_valid_q;

    fix8_t             out_data_q;
    logic              out_valid_q;

    prod_t             s2_prod_d;
    fix8_t             out_data_d;

    assign en          = !out_valid_q || out_ready;
    assign in_ready    = en;
    assign lut_address = s0_data_q[DATA_W-1 -: ADDR_W];
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

    forget_sig_interp_mac u_mac (
        .base_i     (s1_base_q),
        .next_i     (s1_next_q),
        .frac_i     (s1_frac_q),
        .prod_o     (s2_prod_d),
        .acc_base_i (s2_base_q),
        .acc_prod_i (s2_prod_q),
        .sum_o      (out_data_d)
    );

    // One global enable: a stalled output freezes every stage, including the LUT address.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_data_q   <= '0;
            s0_valid_q  <= 1'b0;
            s1_base_q   <= '0;
            s1_next_q   <= '0;
            s1_frac_q   <= '0;
            s1_valid_q  <= 1'b0;
            s2_base_q   <= '0;
            s2_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            s0_data_q   <= in_data;
            s0_valid_q  <= in_valid;
            s1_base_q   <= fix8_t'(lut_base);
            s1_next_q   <= fix8_t'(lut_next);
            s1_frac_q   <= s0_data_q[FRAC_W-1:0];
            s1_valid_q  <= s0_valid_q;
            s2_base_q   <= s1_base_q;
            s2_prod_q   <= s2_prod_d;
            s2_valid_q  <= s1_valid_q;
            out_data_q  <= out_data_d;
            out_valid_q <= s2_valid_q;
        end
    end

endmodule

// File: tb/tb_forget_sig_interp.sv
// Directed bench for forget_sig_interp with a behavioural LUT (forget table plus an alternate table).
module tb_forget_sig_interp;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] lut_address;
    logic [7:0] lut_base;
    logic [7:0] lut_next;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int passed = 0;
    int total  = 0;

    logic signed [7:0] lut_f [16];
    logic signed [7:0] lut_a [16];
    bit                alt;

    always #5 clk = ~clk;

    forget_sig_interp dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    // Forget table clamps the top segment; the alternate table wraps everywhere.
    always_comb begin
        logic [3:0] nx;
        nx = lut_address + 4'd1;
        if (alt) begin
            lut_base = lut_a[lut_address];
            lut_next = lut_a[nx];
        end else begin
            lut_base = lut_f[lut_address];
            lut_next = (lut_address == 4'd7) ? lut_f[7] : lut_f[nx];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [7:0] din, input logic [3:0] addr,
                           input int dout, input int idx);
        out_ready = 1'b1;
        in_data   = din;
        in_valid  = 1'b1;
        chk($sformatf("v%0d in_ready", idx), int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk($sformatf("v%0d lut_address", idx), int'(lut_address), int'(addr));
        tick();
        chk($sformatf("v%0d valid@1", idx), int'(out_valid), 0);
        tick();
        chk($sformatf("v%0d valid@2", idx), int'(out_valid), 0);
        tick();
        chk($sformatf("v%0d valid@3", idx), int'(out_valid), 1);
        chk($sformatf("v%0d out_data", idx), int'($signed(out_data)), dout);
        tick();
        chk($sformatf("v%0d consumed", idx), int'(out_valid), 0);
    endtask

    typedef struct {
        logic [7:0] din;
        bit         alt;
        logic [3:0] addr;
        int         dout;
    } vec_t;

    vec_t vecs [10];

    // Output monitor: collects transfers and checks stall behaviour.
    bit                mon_en = 1'b0;
    bit                stall_prev;
    logic [7:0]        stall_data;
    logic signed [7:0] got [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) got.push_back($signed(out_data));
            if (stall_prev) begin
                chk("stall out_valid held", int'(out_valid), 1);
                chk("stall out_data held", int'(out_data), int'(stall_data));
            end
            if (out_valid && !out_ready) chk("stall in_ready low", int'(in_ready), 0);
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    logic [7:0] strm [4];
    int         exp_strm [4];

    initial begin
        lut_f = '{8'sd8, 8'sd11, 8'sd14, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15,
                  8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd4};
        lut_a = '{8'sd10, 8'sd5, -8'sd128, 8'sd127, -8'sd128, 8'sd0, 8'sd0, 8'sd0,
                  8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        vecs[0] = '{8'h00, 1'b0, 4'd0,  8};
        vecs[1] = '{8'h08, 1'b0, 4'd0,  9};
        vecs[2] = '{8'hE8, 1'b0, 4'd14, 2};
        vecs[3] = '{8'h78, 1'b0, 4'd7,  15};
        vecs[4] = '{8'h80, 1'b0, 4'd8,  0};
        vecs[5] = '{8'hF8, 1'b0, 4'd15, 6};
        vecs[6] = '{8'h01, 1'b1, 4'd0,  9};
        vecs[7] = '{8'h1F, 1'b1, 4'd1,  -120};
        vecs[8] = '{8'h2F, 1'b1, 4'd2,  111};
        vecs[9] = '{8'h38, 1'b1, 4'd3,  -1};
        strm     = '{8'h00, 8'h08, 8'h78, 8'hF8};
        exp_strm = '{8, 9, 15, 6};

        alt       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset lut_address", int'(lut_address), 0);
        chk("reset in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            alt = vecs[i].alt;
            run_vec(vecs[i].din, vecs[i].addr, vecs[i].dout, i);
        end
        alt = 1'b0;

        // Stream with a gap, then a 4-cycle output stall while an input is pending.
        begin
            int k;
            bit acc;
            k = 0;
            got.delete();
            stall_prev = 1'b0;
            mon_en = 1'b1;
            for (int c = 0; c < 40; c++) begin
                out_ready = !(c >= 4 && c <= 7);
                in_valid  = (k < 4) && (k < 2 || c >= 4);
                in_data   = strm[(k < 4) ? k : 0];
                @(negedge clk);
                acc = in_valid && in_ready;
                tick();
                if (acc) k++;
            end
            in_valid = 1'b0;
            mon_en = 1'b0;
            chk("stream accepted", k, 4);
            chk("stream result count", got.size(), 4);
            for (int i = 0; i < 4; i++)
                chk($sformatf("stream result %0d", i),
                    (i < got.size()) ? int'(got[i]) : -999, exp_strm[i]);
        end

        // Reset with two items in flight.
        got.delete();
        stall_prev = 1'b0;
        mon_en     = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h00;
        tick();
        in_data = 8'h08;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("flush out_valid", int'(out_valid), 0);
        chk("flush in_ready", int'(in_ready), 1);
        chk("flush lut_address", int'(lut_address), 0);
        repeat (6) tick();
        mon_en = 1'b0;
        chk("flush no stale outputs", got.size(), 0);
        run_vec(8'h00, 4'd0, 8, 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
